// File: rtl/axis_flit_deserializer_pkg.sv
// Shared defaults and width helper for the flit deserializer egress endpoint.
package axis_flit_deserializer_pkg;

    localparam int DEF_TDATA_WIDTH          = 512;
    localparam int DEF_DEST_WIDTH           = 6;
    localparam int DEF_SERIALIZATION_FACTOR = 4;
    localparam int DEF_FLIT_BUFFER_DEPTH    = 4;

    // Bits needed to index n distinct values; never less than one bit.
    function automatic int f_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_flit_deserializer_fifo.sv
// Synchronous flit FIFO with registered full/empty and wrap-bit pointers.
module axis_flit_deserializer_fifo
    import axis_flit_deserializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = f_width(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;
    logic             r_full;
    logic             r_empty;

    assign w_wr_nxt = r_wr_ptr + PW'(i_wr_en);
    assign w_rd_nxt = r_rd_ptr + PW'(i_rd_en);

    // Flags are computed from next pointers so a new entry is only visible a cycle after its write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_empty  <= (w_wr_nxt == w_rd_nxt);
            r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/axis_flit_deserializer.sv
// NoC egress endpoint: buffers credit-governed flits and packs SERIALIZATION_FACTOR of them per AXIS beat.
module axis_flit_deserializer
    import axis_flit_deserializer_pkg::*;
#(
    parameter int TDATA_WIDTH          = DEF_TDATA_WIDTH,
    parameter int DEST_WIDTH           = DEF_DEST_WIDTH,
    parameter int SERIALIZATION_FACTOR = DEF_SERIALIZATION_FACTOR,
    parameter int FLIT_BUFFER_DEPTH    = DEF_FLIT_BUFFER_DEPTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
    input  logic [DEST_WIDTH-1:0]                       dest_in,
    input  logic                                        is_tail_in,
    input  logic                                        send_in,
    output logic                                        credit_out,
    output logic                                        axis_tvalid,
    input  logic                                        axis_tready,
    output logic [TDATA_WIDTH-1:0]                      axis_tdata,
    output logic                                        axis_tlast,
    output logic [DEST_WIDTH-1:0]                       axis_tdest,
    output logic                                        err_overflow,
    output logic                                        err_framing
);

    localparam int FW = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int CW = f_width(SERIALIZATION_FACTOR + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SERIALIZATION_FACTOR);
    localparam logic [CW-1:0] LAST_IDX = CW'(SERIALIZATION_FACTOR - 1);

    typedef struct packed {
        logic [FW-1:0]         data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    flit_t                  w_wr_flit;
    flit_t                  w_rd_flit;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_handshake;
    logic [CW-1:0]          w_slot;
    logic [CW-1:0]          w_count_next;
    logic [CW-1:0]          r_count;
    logic                   r_tvalid;
    logic                   r_credit;
    logic                   r_tlast;
    logic [DEST_WIDTH-1:0]  r_tdest;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_err_overflow;
    logic                   r_err_framing;

    assign w_wr_flit   = '{data: data_in, dest: dest_in, is_tail: is_tail_in};
    assign w_handshake = r_tvalid && axis_tready;
    // A full beat only accepts the next flit when it is leaving in the same cycle.
    assign w_pop       = !w_empty && ((r_count < FULL_CNT) || w_handshake);
    assign w_wr_en     = send_in && (!w_full || w_pop);
    assign w_slot      = w_handshake ? '0 : r_count;

    axis_flit_deserializer_fifo #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (FLIT_BUFFER_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_flit),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_flit),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_count_next = r_count;
        if (w_handshake && w_pop) begin
            w_count_next = CW'(1);
        end else if (w_handshake) begin
            w_count_next = '0;
        end else if (w_pop) begin
            w_count_next = r_count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_tvalid <= 1'b0;
            r_credit <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_tvalid <= (w_count_next == FULL_CNT);
            r_credit <= w_pop;
        end
    end

    // Slot 0 supplies the beat's dest, the final slot supplies its tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata <= '0;
            r_tdest <= '0;
            r_tlast <= 1'b0;
        end else if (w_pop) begin
            for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
                if (w_slot == CW'(k)) begin
                    r_tdata[k*FW +: FW] <= w_rd_flit.data;
                end
            end
            if (w_slot == '0) begin
                r_tdest <= w_rd_flit.dest;
            end
            if (w_slot == LAST_IDX) begin
                r_tlast <= w_rd_flit.is_tail;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
            r_err_framing  <= 1'b0;
        end else begin
            if (send_in && w_full && !w_pop) begin
                r_err_overflow <= 1'b1;
            end
            if (w_pop && w_rd_flit.is_tail && (w_slot != LAST_IDX)) begin
                r_err_framing <= 1'b1;
            end
        end
    end

    assign credit_out   = r_credit;
    assign axis_tvalid  = r_tvalid;
    assign axis_tdata   = r_tdata;
    assign axis_tdest   = r_tdest;
    assign axis_tlast   = r_tlast;
    assign err_overflow = r_err_overflow;
    assign err_framing  = r_err_framing;

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Randomised bench for axis_flit_deserializer against a flit-queue reference model.
module tb_axis_flit_deserializer;

    localparam int TW = 512;
    localparam int DW = 6;
    localparam int S  = 4;
    localparam int D  = 4;
    localparam int FW = TW / S;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [TW-1:0] axis_tdata;
    logic          axis_tlast;
    logic [DW-1:0] axis_tdest;
    logic          err_overflow;
    logic          err_framing;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int creditCnt = 0;
    int creditBase = 0;
    int sentCnt = 0;

    logic [FW-1:0] expData [$];
    logic [DW-1:0] expDest [$];
    logic          expTail [$];
    logic [TW-1:0] obsData [$];
    logic [DW-1:0] obsDest [$];
    logic          obsLast [$];
    int            obsCyc  [$];

    axis_flit_deserializer #(
        .TDATA_WIDTH          (TW),
        .DEST_WIDTH           (DW),
        .SERIALIZATION_FACTOR (S),
        .FLIT_BUFFER_DEPTH    (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tdata   (axis_tdata),
        .axis_tlast   (axis_tlast),
        .axis_tdest   (axis_tdest),
        .err_overflow (err_overflow),
        .err_framing  (err_framing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat and credit observation happens mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (axis_tvalid && axis_tready) begin
                obsData.push_back(axis_tdata);
                obsDest.push_back(axis_tdest);
                obsLast.push_back(axis_tlast);
                obsCyc.push_back(cyc);
            end
            if (credit_out) creditCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] randFlit();
        logic [FW-1:0] v;
        for (int k = 0; k < FW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic clearModel();
        expData.delete(); expDest.delete(); expTail.delete();
        obsData.delete(); obsDest.delete(); obsLast.delete(); obsCyc.delete();
        sentCnt    = 0;
        creditBase = creditCnt;
    endtask

    task automatic doReset();
        rst = 1'b1;
        send_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        clearModel();
    endtask

    task automatic sendFlit(input logic [FW-1:0] d, input logic [DW-1:0] de,
                            input logic tail, input logic accepted);
        data_in    = d;
        dest_in    = de;
        is_tail_in = tail;
        send_in    = 1'b1;
        step();
        send_in    = 1'b0;
        is_tail_in = 1'b0;
        if (accepted) begin
            expData.push_back(d);
            expDest.push_back(de);
            expTail.push_back(tail);
            sentCnt++;
        end
    endtask

    // Upstream behaviour: only send while a credit is available.
    task automatic sendCredited(input int n, input int offset);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while ((D + (creditCnt - creditBase) - sentCnt) <= 0 && w < 200) begin
                step();
                w++;
            end
            if (w >= 200) begin
                checks++;
                $display("[TB] FAIL credit_wait: no credit after %0d cycles, required one", w);
                return;
            end
            sendFlit(randFlit(), DW'($urandom()),
                     ((i + offset) % S == S - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
        end
    endtask

    task automatic waitBeats(input string name, input int n);
        int w;
        w = 0;
        while (obsData.size() < n && w < 300) begin
            step();
            w++;
        end
        if (obsData.size() < n) begin
            checks++;
            $display("[TB] FAIL %s_beat_timeout: got %0d beats, required %0d", name, obsData.size(), n);
        end
    endtask

    task automatic modelBeat(input int b, output logic [TW-1:0] ed,
                             output logic [DW-1:0] edst, output logic el);
        ed = '0;
        for (int k = 0; k < S; k++) ed[k*FW +: FW] = expData[b*S + k];
        edst = expDest[b*S];
        el   = expTail[b*S + S - 1];
    endtask

    task automatic checkBeats(input string name);
        logic [TW-1:0] ed;
        logic [DW-1:0] edst;
        logic          el;
        logic [TW-1:0] od;
        logic [DW-1:0] odst;
        logic          ol;
        while (obsData.size() > 0) begin
            od = obsData.pop_front();
            odst = obsDest.pop_front();
            ol = obsLast.pop_front();
            void'(obsCyc.pop_front());
            checks++;
            if (expData.size() < S) begin
                $display("[TB] FAIL %s_extra_beat: beat %h seen, required none", name, od);
                continue;
            end
            passes++;
            modelBeat(0, ed, edst, el);
            for (int k = 0; k < S; k++) begin
                void'(expData.pop_front());
                void'(expDest.pop_front());
                void'(expTail.pop_front());
            end
            checks++;
            if (od !== ed) $display("[TB] FAIL %s_tdata: got %h required %h", name, od, ed);
            else passes++;
            checks++;
            if (odst !== edst) $display("[TB] FAIL %s_tdest: got %h required %h", name, odst, edst);
            else passes++;
            checks++;
            if (ol !== el) $display("[TB] FAIL %s_tlast: got %b required %b", name, ol, el);
            else passes++;
        end
        checks++;
        if (expData.size() != 0) $display("[TB] FAIL %s_residual: %0d flits never delivered, required 0", name, expData.size());
        else passes++;
    endtask

    task automatic checkCredits(input string name, input int c0, input int n);
        checks++;
        if (creditCnt - c0 !== n) $display("[TB] FAIL %s_credits: got %0d required %0d", name, creditCnt - c0, n);
        else passes++;
    endtask

    task automatic test_reset();
        logic [TW-1:0] k;
        doReset();
        checks++;
        if ({axis_tvalid, axis_tlast, credit_out, err_overflow, err_framing, axis_tdest, axis_tdata} !== '0)
            $display("[TB] FAIL reset_outputs: tvalid=%b credit=%b tdata=%h required all 0", axis_tvalid, credit_out, axis_tdata);
        else passes++;
        axis_tready = 1'b0;
        sendCredited(6, 0);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({axis_tvalid, axis_tlast, credit_out, axis_tdest, axis_tdata} !== '0)
            $display("[TB] FAIL midreset_outputs: tvalid=%b tdata=%h required all 0", axis_tvalid, axis_tdata);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (credit_out !== 1'b0) $display("[TB] FAIL midreset_credit: got %b required 0", credit_out);
        else passes++;
        rst = 1'b0;
        clearModel();
        step();
        axis_tready = 1'b1;
        sendFlit(FW'('h11), 6'h05, 1'b0, 1'b1);
        sendFlit(FW'('h22), 6'h06, 1'b0, 1'b1);
        sendFlit(FW'('h33), 6'h07, 1'b0, 1'b1);
        sendFlit(FW'('h44), 6'h08, 1'b1, 1'b1);
        waitBeats("reset", 1);
        k = '0;
        k[0*FW +: FW] = FW'('h11);
        k[1*FW +: FW] = FW'('h22);
        k[2*FW +: FW] = FW'('h33);
        k[3*FW +: FW] = FW'('h44);
        checks++;
        if (obsData[0] !== k) $display("[TB] FAIL reset_first_beat: got %h required %h", obsData[0], k);
        else passes++;
        checkBeats("reset");
    endtask

    task automatic test_back_to_back();
        int t0;
        int c0;
        axis_tready = 1'b1;
        c0 = creditCnt;
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            sendFlit(randFlit(), 6'd3, (i % S == S - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
        waitBeats("b2b", 2);
        checks++;
        if (obsCyc[0] !== t0 + 5) $display("[TB] FAIL b2b_beat0_cycle: got %0d required %0d", obsCyc[0], t0 + 5);
        else passes++;
        checks++;
        if (obsCyc[1] !== t0 + 9) $display("[TB] FAIL b2b_beat1_cycle: got %0d required %0d", obsCyc[1], t0 + 9);
        else passes++;
        checkBeats("b2b");
        repeat (4) step();
        checkCredits("b2b", c0, 8);
    endtask

    task automatic test_backpressure();
        int c0;
        logic [TW-1:0] ed;
        logic [DW-1:0] edst;
        logic          el;
        axis_tready = 1'b0;
        c0 = creditCnt;
        sendCredited(8, 0);
        repeat (6) step();
        checks++;
        if (axis_tvalid !== 1'b1) $display("[TB] FAIL bp_tvalid_held: got %b required 1", axis_tvalid);
        else passes++;
        checkCredits("bp_stalled", c0, 4);
        repeat (5) step();
        modelBeat(0, ed, edst, el);
        checks++;
        if (axis_tdata !== ed) $display("[TB] FAIL bp_held_tdata: got %h required %h", axis_tdata, ed);
        else passes++;
        axis_tready = 1'b1;
        waitBeats("bp", 2);
        checkBeats("bp");
        repeat (4) step();
        checkCredits("bp_total", c0, 8);
    endtask

    task automatic test_simultaneous();
        axis_tready = 1'b0;
        sendCredited(8, 0);
        repeat (4) step();
        axis_tready = 1'b1;
        sendFlit(randFlit(), DW'($urandom()), 1'b0, 1'b1);
        checks++;
        if (err_overflow !== 1'b0) $display("[TB] FAIL sim_overflow: got %b required 0", err_overflow);
        else passes++;
        sendCredited(3, 1);
        waitBeats("sim", 3);
        checkBeats("sim");
        checks++;
        if ({err_overflow, err_framing} !== 2'b00) $display("[TB] FAIL sim_err_flags: got %b required 00", {err_overflow, err_framing});
        else passes++;
    endtask

    task automatic test_framing();
        axis_tready = 1'b1;
        checks++;
        if (err_framing !== 1'b0) $display("[TB] FAIL frm_clear: got %b required 0", err_framing);
        else passes++;
        for (int i = 0; i < S; i++) sendFlit(randFlit(), DW'($urandom()), (i == 1), 1'b1);
        waitBeats("frm", 1);
        step();
        checks++;
        if (err_framing !== 1'b1) $display("[TB] FAIL frm_flag: got %b required 1", err_framing);
        else passes++;
        checkBeats("frm");
        sendFlit(randFlit(), 6'h2A, 1'b0, 1'b1);
        for (int i = 1; i < S; i++) sendFlit(randFlit(), DW'($urandom()), (i == S - 1), 1'b1);
        waitBeats("tlast", 1);
        checks++;
        if (obsLast[0] !== 1'b1) $display("[TB] FAIL tlast_set: got %b required 1", obsLast[0]);
        else passes++;
        checks++;
        if (obsDest[0] !== 6'h2A) $display("[TB] FAIL tlast_tdest: got %h required 2a", obsDest[0]);
        else passes++;
        checkBeats("tlast");
    endtask

    task automatic test_overflow();
        int c0;
        checks++;
        if (err_overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b required 0", err_overflow);
        else passes++;
        axis_tready = 1'b0;
        c0 = creditCnt;
        sendCredited(8, 0);
        repeat (4) step();
        sendFlit(randFlit(), DW'($urandom()), 1'b0, 1'b0);
        step();
        checks++;
        if (err_overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got %b required 1", err_overflow);
        else passes++;
        axis_tready = 1'b1;
        waitBeats("ovf", 2);
        repeat (20) step();
        checks++;
        if (obsData.size() !== 2) $display("[TB] FAIL ovf_beat_count: got %0d required 2", obsData.size());
        else passes++;
        checkBeats("ovf");
        checkCredits("ovf", c0, 8);
        doReset();
        checks++;
        if ({err_overflow, err_framing} !== 2'b00) $display("[TB] FAIL flags_after_reset: got %b required 00", {err_overflow, err_framing});
        else passes++;
    endtask

    initial begin
        rst         = 1'b1;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_framing();
        test_overflow();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
